// File: rtl/bcd_scan_driver.sv
// Binary-to-BCD converter (double dabble, one bit per cycle) feeding a
// time-multiplexed seven-segment scanner with optional leading-zero blanking.
module bcd_scan_driver #(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 5,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    input  logic                  blank_en,
    output logic                  busy,
    output logic                  bcd_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [3:0]            digit_data,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic [WIDTH-1:0]   sr;
    logic [PS_W-1:0]    presc;
    logic [IDX_W-1:0]   idx;
    logic [DIGITS-1:0]  blank;
    logic               zero_above;

    // Add-3 correction on every nibble >= 5, then shift {acc, bin} left by one.
    function automatic logic [ACC_W+WIDTH-1:0] dabble_step(
        input logic [ACC_W-1:0] acc_in,
        input logic [WIDTH-1:0] bin_in
    );
        logic [ACC_W-1:0] adj;
        adj = acc_in;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
        return {adj, bin_in} << 1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            bcd_valid <= 1'b0;
            bcd       <= '0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= DONE;
                end
                DONE: begin
                    bcd       <= acc;
                    bcd_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift datapath carries no reset; it is always reloaded when a load is accepted.
    always_ff @(posedge clk) begin
        if (state == IDLE && load) begin
            sr  <= value;
            acc <= '0;
        end else if (state == SHIFT) begin
            {acc, sr} <= dabble_step(acc, sr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PS_W'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A digit is blank when it and every more significant digit are zero.
    always_comb begin
        zero_above = 1'b1;
        blank      = '0;
        digit_sel  = '1;
        digit_data = 4'h0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (bcd[4*i +: 4] == 4'h0);
            blank[i]   = blank_en && (i > 0) && zero_above;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                digit_sel[i] = 1'b0;
                digit_data   = blank[i] ? 4'hF : bcd[4*i +: 4];
            end
        end
    end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Bench for bcd_scan_driver: decimal-arithmetic reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_bcd_scan_driver;

    localparam int WIDTH    = 16;
    localparam int DIGITS   = 5;
    localparam int SCAN_DIV = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 load = 1'b0;
    logic [WIDTH-1:0]     value = '0;
    logic                 blank_en = 1'b0;
    logic                 busy;
    logic                 bcd_valid;
    logic [4*DIGITS-1:0]  bcd;
    logic [3:0]           digit_data;
    logic [DIGITS-1:0]    digit_sel;

    int n_cmp = 0;
    int n_bad = 0;
    int busy_cnt = 0;
    int valid_cnt = 0;

    int m_remain = 0;
    int m_pending = 0;
    int m_shown = 0;
    int m_cyc = 0;
    bit m_valid = 1'b0;

    bcd_scan_driver #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .blank_en(blank_en),
        .busy(busy), .bcd_valid(bcd_valid), .bcd(bcd),
        .digit_data(digit_data), .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_digit(input int v, input int i, input bit blk);
        int p;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (blk && i > 0 && v < p) return 4'hF;
        return 4'((v / p) % 10);
    endfunction

    // Reference: a conversion is a WIDTH+1 cycle delay; scan index is elapsed cycles / SCAN_DIV.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_remain = 0; m_pending = 0; m_shown = 0; m_cyc = 0; m_valid = 1'b0;
        end else begin
            m_cyc++;
            m_valid = 1'b0;
            if (m_remain == 0) begin
                if (load) begin
                    m_remain = WIDTH + 1;
                    m_pending = int'(value);
                end
            end else begin
                m_remain--;
                if (m_remain == 0) begin
                    m_shown = m_pending;
                    m_valid = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int ix;
        logic [DIGITS-1:0] es;
        ix = (m_cyc / SCAN_DIV) % DIGITS;
        es = '1;
        es[ix] = 1'b0;
        check("busy", busy, m_remain != 0);
        check("bcd_valid", bcd_valid, m_valid);
        check("bcd", bcd, to_bcd(m_shown));
        check("digit_sel", digit_sel, es);
        check("digit_data", digit_data, exp_digit(m_shown, ix, blank_en));
        if (busy) busy_cnt++;
        if (bcd_valid) valid_cnt++;
    end

    task automatic do_load(input int v);
        @(posedge clk); #1;
        load = 1'b1;
        value = WIDTH'(v);
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic frame_check(input string name, input logic [3:0] d [DIGITS]);
        logic [DIGITS-1:0] prev;
        logic [DIGITS-1:0] es;
        bit found;
        found = 1'b0;
        prev = digit_sel;
        for (int k = 0; k < 4 * DIGITS * SCAN_DIV && !found; k++) begin
            @(negedge clk);
            if (digit_sel == 5'b11110 && prev == 5'b01111) found = 1'b1;
            else prev = digit_sel;
        end
        check({name, "_sync"}, found, 1'b1);
        if (found) begin
            for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
                if (k > 0) @(negedge clk);
                es = '1;
                es[k / SCAN_DIV] = 1'b0;
                check({name, "_sel"}, digit_sel, es);
                check({name, "_data"}, digit_data, d[k / SCAN_DIV]);
            end
        end
    endtask

    initial begin
        bit got;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_bcd", bcd, 20'h00000);
        check("rst_sel", digit_sel, 5'b11110);
        check("rst_data", digit_data, 4'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        busy_cnt = 0; valid_cnt = 0;
        do_load(65535);
        repeat (25) @(posedge clk);
        check("max_busy_cycles", busy_cnt, 17);
        check("max_valid_pulses", valid_cnt, 1);
        check("max_bcd", bcd, 20'h65535);

        blank_en = 1'b1;
        do_load(0);
        repeat (25) @(posedge clk);
        check("zero_bcd", bcd, 20'h00000);
        frame_check("zero_blank", '{4'h0, 4'hF, 4'hF, 4'hF, 4'hF});

        do_load(1234);
        repeat (25) @(posedge clk);
        check("n1234_bcd", bcd, 20'h01234);
        frame_check("n1234_blank", '{4'h4, 4'h3, 4'h2, 4'h1, 4'hF});
        blank_en = 1'b0;
        frame_check("n1234_noblank", '{4'h4, 4'h3, 4'h2, 4'h1, 4'h0});

        busy_cnt = 0; valid_cnt = 0;
        do_load(100);
        repeat (5) @(posedge clk);
        do_load(999);
        check("mid_hold_bcd", bcd, 20'h01234);
        repeat (25) @(posedge clk);
        check("mid_bcd", bcd, 20'h00100);
        check("mid_valid_pulses", valid_cnt, 1);

        do_load(77);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); #1;
            if (bcd_valid) got = 1'b1;
        end
        check("b2b_valid_seen", got, 1'b1);
        load = 1'b1;
        value = 16'd555;
        @(posedge clk); #1;
        load = 1'b0;
        check("b2b_accepted_busy", busy, 1'b1);
        check("b2b_first_bcd", bcd, 20'h00077);
        repeat (25) @(posedge clk);
        check("b2b_second_bcd", bcd, 20'h00555);

        busy_cnt = 0; valid_cnt = 0;
        do_load(4321);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_bcd", bcd, 20'h00000);
        check("abort_sel", digit_sel, 5'b11110);
        check("abort_data", digit_data, 4'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("abort_no_valid", valid_cnt, 0);
        do_load(4321);
        repeat (25) @(posedge clk);
        check("after_abort_bcd", bcd, 20'h04321);
        check("after_abort_valid", valid_cnt, 1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
